fp_mult_round: RTL and testbench
================================

Name: fp_mult_round

Overview:
- Pipelined normalise/round/pack stage that sits directly downstream of the single-precision FP multiplier's DSP48E1 mantissa product.
- Consumes the sign, the biased exponent sum, the raw 48-bit 24x24 mantissa product and the upstream special-case flags.
- Produces an IEEE-754 single-precision result plus exception flags under a valid/ready handshake.
- Also keeps a sticky exception-status register.

Parameters:
- PIPE_OUT, 1, 1 = stage-2 result registered (latency 2); 0 = reserved, the only supported value is 1.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- InValid  input  1  upstream data valid
- InReady  output  1  stage can accept this cycle
- Sign  input  1  product sign (Sa xor Sb)
- ExpSum  input  10  two's-complement Ea+Eb-127, before normalisation
- Mant  input  48  raw unsigned mantissa product
- InZero, InInf, InNaN  input  1 each  upstream special-operand flags
- Ctrl  input  3  [1:0] rounding mode (00 RNE, 01 RTZ, 10 RUP, 11 RDN); [2] saturate overflow to max finite
- OutValid  output  1  result valid
- OutReady  input  1  downstream accepts
- P  output  32  packed result
- Flags  output  4  {Invalid, Overflow, Underflow, Inexact} for the current result
- FlagClr  input  1  clears the sticky status
- Status  output  4  sticky OR of Flags over all accepted results

Behaviour:
- Reset (async, any time, including mid-operation):
  - Both pipeline valids, OutValid, P, Flags and Status go to 0.
  - Data in flight is discarded.
  - InReady is 1 after reset deasserts.
- Handshake:
  - Transfer in when InValid&InReady; transfer out when OutValid&OutReady.
  - Stage 2 loads when !OutValid | OutReady.
  - InReady = !s1_valid | stage-2-load. This combinational OutReady->InReady path is intended.
  - Data is held stable while OutValid&!OutReady.
  - Strict in-order delivery, no drops, no duplicates.
  - Back-to-back transfers give one result per cycle.
- Latency: exactly 2 cycles from input transfer to OutValid when unstalled.
- Ctrl is sampled with the data in stage 1 and carried down the pipe.
- Stage 1 (normalise):
  - If Mant[47]=1: kept = Mant[47:24], G = Mant[23], S = |Mant[22:0], E = ExpSum+1.
  - Else: kept = Mant[46:23], G = Mant[22], S = |Mant[21:0], E = ExpSum.
  - E uses 11-bit signed arithmetic, so no wrap.
- Stage 2 (round, range check, pack):
  - Increment rules:
    - RNE: G&(S|kept[0]).
    - RTZ: 0.
    - RUP: (G|S)&!Sign.
    - RDN: (G|S)&Sign.
  - A carry out of 24 bits sets mantissa to 0x800000 and E+1.
  - Inexact = G|S for normal results.
  - E>=255 -> overflow; Overflow=1, Inexact=1. Result is:
    - Inf when RNE; when RUP and positive; when RDN and negative.
    - Otherwise max finite 0x7F7FFFFF with sign.
    - Ctrl[2]=1 forces max finite regardless of mode.
  - E<=0 -> flush to signed zero; Underflow=1, Inexact=1. No subnormal outputs.
  - Normal packing: P = {Sign, E[7:0], mant[22:0]}.
- Special priority, applied instead of arithmetic:
  1. InNaN, or InInf&InZero -> P = 0x7FC00000. Invalid=1 only for InInf&InZero. Other flags 0.
  2. InInf -> {Sign, 0xFF, 0}.
  3. InZero, or Mant==0 -> {Sign, 31'b0}.
- Status:
  - Status |= Flags on each output transfer.
  - FlagClr clears Status. FlagClr wins over a simultaneous transfer's OR, so that transfer's flags are lost.

Test Plan:
- 1.5x1.5: Sign=0, ExpSum=127, Mant=0x900000000000, RNE -> P=0x40100000, Flags=0, OutValid exactly 2 cycles after accept.
- Tie rounding, ExpSum=127:
  - Mant=0x400000400000: RNE -> 0x3F800000, Inexact; RUP -> 0x3F800001; RTZ -> 0x3F800000.
  - Mant=0x400000C00000: RNE -> 0x3F800002.
- Overflow: ExpSum=254, Mant=0x800000000000, Sign=0:
  - RNE -> 0x7F800000, Flags=0b0101.
  - Ctrl=3'b100 -> 0x7F7FFFFF.
  - RDN -> 0x7F7FFFFF.
- Underflow: Sign=1, ExpSum=0, Mant=0x400000000000 -> P=0x80000000, Flags=0b0011. Then FlagClr -> Status=0.
- Specials:
  - InInf&InZero -> 0x7FC00000, Invalid.
  - InInf with Sign=1 -> 0xFF800000.
  - InNaN -> 0x7FC00000 with Invalid=0.
- Backpressure/reset:
  - OutReady=0 with 4 back-to-back inputs -> InReady drops after 2 accepts; releasing OutReady delivers all in order, one per cycle.
  - Asserting rst mid-stream -> OutValid=0, Status=0 immediately (asynchronous).

Source files
------------

// File: rtl/fp_mult_round.sv
// Normalise, round and pack stage for the single-precision multiplier datapath.
// Two registered stages with valid/ready flow control and a sticky exception register.
module fp_mult_round #(
  parameter int PIPE_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic        Sign,
  input  logic [9:0]  ExpSum,
  input  logic [47:0] Mant,
  input  logic        InZero,
  input  logic        InInf,
  input  logic        InNaN,
  input  logic [2:0]  Ctrl,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] P,
  output logic [3:0]  Flags,
  input  logic        FlagClr,
  output logic [3:0]  Status
);

  generate
    if (PIPE_OUT != 1) begin : g_param_check
      $error("fp_mult_round: only PIPE_OUT=1 is supported");
    end
  endgenerate

  logic               s1_valid_reg;
  logic               s1_sign_reg;
  logic signed [10:0] s1_exp_reg;
  logic [23:0]        s1_kept_reg;
  logic               s1_g_reg;
  logic               s1_s_reg;
  logic               s1_zero_reg;
  logic               s1_inf_reg;
  logic               s1_nan_reg;
  logic [2:0]         s1_ctrl_reg;

  logic               s2_load;
  logic signed [10:0] exp_in;

  assign s2_load = !OutValid | OutReady;
  assign InReady = !s1_valid_reg | s2_load;
  // Sign-extend to 11 bits so the normalisation increment can never wrap.
  assign exp_in  = {ExpSum[9], ExpSum} + {10'd0, Mant[47]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_kept_reg  <= '0;
      s1_g_reg     <= 1'b0;
      s1_s_reg     <= 1'b0;
      s1_zero_reg  <= 1'b0;
      s1_inf_reg   <= 1'b0;
      s1_nan_reg   <= 1'b0;
      s1_ctrl_reg  <= '0;
    end else if (InReady) begin
      s1_valid_reg <= InValid;
      s1_sign_reg  <= Sign;
      s1_exp_reg   <= exp_in;
      s1_kept_reg  <= Mant[47] ? Mant[47:24] : Mant[46:23];
      s1_g_reg     <= Mant[47] ? Mant[23] : Mant[22];
      s1_s_reg     <= Mant[47] ? (|Mant[22:0]) : (|Mant[21:0]);
      s1_zero_reg  <= InZero | (Mant == 48'd0);
      s1_inf_reg   <= InInf;
      s1_nan_reg   <= InNaN;
      s1_ctrl_reg  <= Ctrl;
    end
  end

  logic               inc;
  logic [24:0]        sum;
  logic signed [10:0] exp_r;
  logic               to_inf;
  logic [31:0]        p_next;
  logic [3:0]         flags_next;
  logic               unused_hidden;

  // The hidden bit is implicit in the packed format; a carry leaves sum[22:0] at zero.
  assign unused_hidden = sum[23];
  assign to_inf = !s1_ctrl_reg[2] &
                  ((s1_ctrl_reg[1:0] == 2'b00) |
                   ((s1_ctrl_reg[1:0] == 2'b10) & !s1_sign_reg) |
                   ((s1_ctrl_reg[1:0] == 2'b11) & s1_sign_reg));

  always_comb begin
    inc = 1'b0;
    unique case (s1_ctrl_reg[1:0])
      2'b00:   inc = s1_g_reg & (s1_s_reg | s1_kept_reg[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = (s1_g_reg | s1_s_reg) & !s1_sign_reg;
      default: inc = (s1_g_reg | s1_s_reg) & s1_sign_reg;
    endcase
    sum   = {1'b0, s1_kept_reg} + {24'd0, inc};
    exp_r = sum[24] ? (s1_exp_reg + 11'sd1) : s1_exp_reg;

    p_next     = {s1_sign_reg, exp_r[7:0], sum[22:0]};
    flags_next = {3'b000, s1_g_reg | s1_s_reg};
    if (s1_nan_reg | (s1_inf_reg & s1_zero_reg)) begin
      p_next     = 32'h7FC00000;
      flags_next = {s1_inf_reg & s1_zero_reg, 3'b000};
    end else if (s1_inf_reg) begin
      p_next     = {s1_sign_reg, 8'hFF, 23'd0};
      flags_next = 4'b0000;
    end else if (s1_zero_reg) begin
      p_next     = {s1_sign_reg, 31'd0};
      flags_next = 4'b0000;
    end else if (exp_r >= 11'sd255) begin
      p_next     = to_inf ? {s1_sign_reg, 8'hFF, 23'd0} : {s1_sign_reg, 8'hFE, 23'h7FFFFF};
      flags_next = 4'b0101;
    end else if (exp_r <= 11'sd0) begin
      p_next     = {s1_sign_reg, 31'd0};
      flags_next = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutValid <= 1'b0;
      P        <= '0;
      Flags    <= '0;
    end else if (s2_load) begin
      OutValid <= s1_valid_reg;
      if (s1_valid_reg) begin
        P     <= p_next;
        Flags <= flags_next;
      end
    end
  end

  // A clear request takes precedence over flags arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Status <= '0;
    end else if (FlagClr) begin
      Status <= '0;
    end else if (OutValid & OutReady) begin
      Status <= Status | Flags;
    end
  end

endmodule

// File: tb/tb_fp_mult_round.sv
// Randomised scoreboard bench for fp_mult_round against an arithmetic reference model.
module tb_fp_mult_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, InReady, Sign, InZero, InInf, InNaN;
  logic [9:0]  ExpSum;
  logic [47:0] Mant;
  logic [2:0]  Ctrl;
  logic        OutValid, OutReady, FlagClr;
  logic [31:0] P;
  logic [3:0]  Flags, Status;

  always #5 clk = ~clk;

  fp_mult_round #(.PIPE_OUT(1)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .Sign(Sign),
    .ExpSum(ExpSum), .Mant(Mant), .InZero(InZero), .InInf(InInf), .InNaN(InNaN),
    .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady), .P(P), .Flags(Flags),
    .FlagClr(FlagClr), .Status(Status)
  );

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  flags;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         n_out = 0;
  logic [3:0] status_model = 4'b0;
  bit         rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: treat the product as an integer, round by comparing the discarded remainder to half an ulp.
  function automatic logic [35:0] ref_model(input logic sign, input logic [9:0] es,
                                            input logic [47:0] mant, input logic z,
                                            input logic inf, input logic nan,
                                            input logic [2:0] ctrl);
    longint unsigned m, kept, rem, half;
    int e, shift;
    bit up, to_inf;
    if (nan || (inf && z)) return {(inf && z), 3'b000, 32'h7FC00000};
    if (inf) return {4'b0000, sign, 8'hFF, 23'd0};
    if (z || mant == 48'd0) return {4'b0000, sign, 31'd0};
    m = 64'(mant);
    e = int'($signed(es));
    if (m >= 64'h8000_0000_0000) begin shift = 24; e = e + 1; end
    else shift = 23;
    kept = m >> shift;
    rem  = m - (kept << shift);
    half = 64'd1 << (shift - 1);
    case (ctrl[1:0])
      2'd0:    up = (rem > half) || (rem == half && kept[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = (rem != 0) && !sign;
      default: up = (rem != 0) && sign;
    endcase
    if (up) kept = kept + 1;
    if (kept == 64'h100_0000) begin kept = kept >> 1; e = e + 1; end
    if (e >= 255) begin
      to_inf = !ctrl[2] && (ctrl[1:0] == 2'd0 || (ctrl[1:0] == 2'd2 && !sign) ||
                            (ctrl[1:0] == 2'd3 && sign));
      return {4'b0101, sign, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
    end
    if (e <= 0) return {4'b0011, sign, 31'd0};
    return {3'b000, (rem != 0), sign, 8'(e), kept[22:0]};
  endfunction

  task automatic send(input logic s, input logic [9:0] es, input logic [47:0] m,
                      input logic z, input logic i, input logic n, input logic [2:0] c);
    bit acc = 1'b0;
    logic [35:0] r;
    exp_t e;
    Sign = s; ExpSum = es; Mant = m; InZero = z; InInf = i; InNaN = n; Ctrl = c;
    InValid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = InReady;
      if (acc) begin
        r = ref_model(s, es, m, z, i, n, c);
        e.p = r[31:0];
        e.flags = r[35:32];
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    InValid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && sb.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit xfer;
    if (!rst) begin
      chk("status", {28'd0, Status}, {28'd0, status_model});
      xfer = OutValid && OutReady;
      e = '0;
      if (xfer) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("xfer %0d P=%h Flags=%b expected P=%h Flags=%b", n_out, P, Flags, e.p, e.flags);
          chk("P", P, e.p);
          chk("Flags", {28'd0, Flags}, {28'd0, e.flags});
          n_out++;
        end
      end
      if (FlagClr) status_model = 4'b0;
      else if (xfer) status_model = status_model | e.flags;
    end
  end

  initial begin
    logic [9:0]  es;
    logic [47:0] m;
    rst = 1'b1; InValid = 1'b0; Sign = 1'b0; ExpSum = '0; Mant = '0;
    InZero = 1'b0; InInf = 1'b0; InNaN = 1'b0; Ctrl = '0; OutReady = 1'b1; FlagClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_p", P, 32'd0);
    chk("rst_flags", {28'd0, Flags}, 32'd0);
    chk("rst_status", {28'd0, Status}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inready", {31'd0, InReady}, 32'd1);
    @(posedge clk); #1;

    // 1.5 x 1.5 with latency check
    send(0, 10'd127, 48'h900000000000, 0, 0, 0, 3'b000);
    chk("latency_c1", {31'd0, OutValid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_c2", {31'd0, OutValid}, 32'd1);

    send(0, 10'd127, 48'h400000400000, 0, 0, 0, 3'b000);
    send(0, 10'd127, 48'h400000400000, 0, 0, 0, 3'b010);
    send(0, 10'd127, 48'h400000400000, 0, 0, 0, 3'b001);
    send(0, 10'd127, 48'h400000C00000, 0, 0, 0, 3'b000);
    send(0, 10'd254, 48'h800000000000, 0, 0, 0, 3'b000);
    send(0, 10'd254, 48'h800000000000, 0, 0, 0, 3'b100);
    send(0, 10'd254, 48'h800000000000, 0, 0, 0, 3'b011);
    send(1, 10'd0,   48'h400000000000, 0, 0, 0, 3'b000);
    send(0, 10'd127, 48'h900000000000, 1, 1, 0, 3'b000);
    send(1, 10'd127, 48'h900000000000, 0, 1, 0, 3'b000);
    send(0, 10'd127, 48'h900000000000, 0, 0, 1, 3'b000);
    send(1, 10'd127, 48'h000000000000, 0, 0, 0, 3'b000);
    drain();

    FlagClr = 1'b1;
    @(posedge clk); #1;
    FlagClr = 1'b0;
    chk("status_clr", {28'd0, Status}, 32'd0);

    // Backpressure: two accepts fill the pipe, then release drains one per cycle
    OutReady = 1'b0;
    send(0, 10'd127, 48'hC00000000001, 0, 0, 0, 3'b000);
    send(1, 10'd130, 48'h600000000003, 0, 0, 0, 3'b010);
    @(negedge clk);
    chk("bp_inready_low", {31'd0, InReady}, 32'd0);
    @(posedge clk); #1;
    fork
      begin
        send(0, 10'd100, 48'hFFFFFFFFFFFF, 0, 0, 0, 3'b000);
        send(1, 10'd140, 48'h7FFFFF800000, 0, 0, 0, 3'b001);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_stream_valid", {31'd0, OutValid}, 32'd1);
        end
      end
    join
    drain();

    // Asynchronous reset mid-stream
    OutReady = 1'b0;
    send(0, 10'd127, 48'hC00000000001, 0, 0, 0, 3'b000);
    send(0, 10'd127, 48'hC00000000001, 0, 0, 0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("async_rst_status", {28'd0, Status}, 32'd0);
    sb.delete();
    status_model = 4'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    chk("post_rst_inready", {31'd0, InReady}, 32'd1);
    @(posedge clk); #1;

    // Randomised traffic with random downstream stalls
    rand_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          case ($urandom_range(0, 3))
            0:       es = 10'($urandom_range(120, 135));
            1:       es = 10'($urandom_range(245, 260));
            2:       es = 10'(int'($urandom_range(0, 8)) - 4);
            default: es = 10'($urandom);
          endcase
          m = {$urandom, $urandom} >> 16;
          if ($urandom_range(0, 1) == 0) m[47] = 1'b1;
          else m[47:46] = 2'b01;
          if ($urandom_range(0, 3) == 0) m[20:0] = '0;
          if ($urandom_range(0, 7) == 0) m[46:24] = '1;
          send($urandom_range(0, 1), es, m,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0, 3'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          OutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OutReady = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
